// File: rtl/l1_cache_pkg.sv
// Shared types for the L1 cache slice.
// Contents: datapath word/line types, cache tag/index types sized for the
// default geometry, the controller state encoding, and a byte-merge helper
// used both for write hits and for line fills.
package l1_cache_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_datbus;

    localparam int LINE_OFFSET_BITS   = 4;
    localparam int LINE_BYTES         = 16;
    localparam int DEFAULT_INDEX_BITS = 3;

    typedef logic [DEFAULT_INDEX_BITS-1:0]      lc3b_cache_index;
    typedef logic [12-DEFAULT_INDEX_BITS-1:0]   lc3b_cache_tag;
    typedef logic [LINE_BYTES-1:0]              lc3b_byte_sel;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESP      = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } l1_state_t;

    // Replace every byte of old_line whose select bit is set with the
    // corresponding byte of new_data; unselected bytes pass through.
    function automatic lc3b_datbus merge_line(input lc3b_datbus   old_line,
                                              input lc3b_datbus   new_data,
                                              input lc3b_byte_sel sel);
        lc3b_datbus r;
        r = old_line;
        for (int i = 0; i < LINE_BYTES; i++) begin
            if (sel[i]) begin
                r[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/l1_cache_array.sv
// Tag / valid / dirty / data storage for the direct-mapped L1 cache.
// Ports:
//   clk, rst_n             clock, synchronous active-low clear of valid/dirty
//   index                  line selected for both read and write
//   rd_valid/rd_dirty/rd_tag/rd_data  combinational read of that line
//   data_we/data_sel/data_in          byte-merged data write
//   tag_we/tag_in                     tag write
//   valid_we/valid_in, dirty_we/dirty_in  state-bit writes
// Tag and data storage are deliberately not reset; only valid/dirty are.
module l1_cache_array
    import l1_cache_pkg::*;
#(
    parameter int INDEX_BITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INDEX_BITS-1:0]   index,
    output logic                    rd_valid,
    output logic                    rd_dirty,
    output logic [11-INDEX_BITS:0]  rd_tag,
    output lc3b_datbus              rd_data,
    input  logic                    data_we,
    input  lc3b_byte_sel            data_sel,
    input  lc3b_datbus              data_in,
    input  logic                    tag_we,
    input  logic [11-INDEX_BITS:0]  tag_in,
    input  logic                    valid_we,
    input  logic                    valid_in,
    input  logic                    dirty_we,
    input  logic                    dirty_in
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 12 - INDEX_BITS;

    logic [TAG_BITS-1:0] tag_q  [LINES];
    lc3b_datbus          data_q [LINES];
    logic [LINES-1:0]    valid_q, valid_d;
    logic [LINES-1:0]    dirty_q, dirty_d;
    lc3b_datbus          data_line_d;

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_data  = data_q[index];

    always_comb begin
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        data_line_d = merge_line(data_q[index], data_in, data_we ? data_sel : '0);
        if (valid_we) begin
            valid_d[index] = valid_in;
        end
        if (dirty_we) begin
            dirty_d[index] = dirty_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[index] <= data_line_d;
        end
        if (tag_we) begin
            tag_q[index] <= tag_in;
        end
    end

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache controller.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cpu_req/addr/wr_en/wr_sel/wdata   pipeline request, held until cpu_resp
//   cpu_resp, cpu_rdata        one-cycle completion pulse and full line
//   mem_read/mem_write/mem_addr/mem_wdata  registered line request to next level
//   mem_resp, mem_rdata        next-level completion and fill data
//   dbg_state                  current controller state
// Handshake: cpu_req is a level held with stable fields until the single
// cycle in which cpu_resp=1; mem_read/mem_write are levels held with stable
// address/data until the single cycle in which mem_resp=1, and drop the
// cycle after. mem_resp outside WRITEBACK/FILL is ignored.
module l1_cache
    import l1_cache_pkg::*;
#(
    parameter int INDEX_BITS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wr_en,
    input  logic [15:0] cpu_wr_sel,
    input  logic [127:0] cpu_wdata,
    output logic        cpu_resp,
    output logic [127:0] cpu_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [127:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [127:0] mem_rdata,
    output l1_state_t   dbg_state
);

    localparam int TAG_BITS = 12 - INDEX_BITS;

    l1_state_t  state_q, state_d;
    logic       cpu_resp_q, cpu_resp_d;
    lc3b_datbus cpu_rdata_q, cpu_rdata_d;
    logic       mem_read_q, mem_read_d;
    logic       mem_write_q, mem_write_d;
    lc3b_word   mem_addr_q, mem_addr_d;
    lc3b_datbus mem_wdata_q, mem_wdata_d;

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  rd_valid, rd_dirty;
    logic [TAG_BITS-1:0]   rd_tag;
    lc3b_datbus            rd_data;
    logic                  hit;
    lc3b_byte_sel          eff_sel;
    lc3b_datbus            merged_line;

    logic                  data_we, tag_we, valid_we, dirty_we, dirty_in;
    lc3b_byte_sel          data_sel;
    lc3b_datbus            data_in;

    // Byte offset only selects within the line, which is returned whole.
    logic unused_offset;
    assign unused_offset = ^cpu_addr[LINE_OFFSET_BITS-1:0];

    assign index   = cpu_addr[LINE_OFFSET_BITS +: INDEX_BITS];
    assign tag     = cpu_addr[15 -: TAG_BITS];
    assign hit     = rd_valid && (rd_tag == tag);
    // Reads behave as a write with no bytes selected.
    assign eff_sel = cpu_wr_en ? cpu_wr_sel : '0;
    assign merged_line = merge_line(rd_data, cpu_wdata, eff_sel);

    l1_cache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .index    (index),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .data_we  (data_we),
        .data_sel (data_sel),
        .data_in  (data_in),
        .tag_we   (tag_we),
        .tag_in   (tag),
        .valid_we (valid_we),
        .valid_in (1'b1),
        .dirty_we (dirty_we),
        .dirty_in (dirty_in)
    );

    always_comb begin
        state_d     = state_q;
        cpu_rdata_d = cpu_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        data_we     = 1'b0;
        data_sel    = eff_sel;
        data_in     = cpu_wdata;
        tag_we      = 1'b0;
        valid_we    = 1'b0;
        dirty_we    = 1'b0;
        dirty_in    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (hit) begin
                        state_d     = RESP;
                        cpu_rdata_d = merged_line;
                        if (eff_sel != '0) begin
                            data_we  = 1'b1;
                            dirty_we = 1'b1;
                            dirty_in = 1'b1;
                        end
                    end else if (rd_valid && rd_dirty) begin
                        state_d     = WRITEBACK;
                        mem_addr_d  = {rd_tag, index, 4'h0};
                        mem_wdata_d = rd_data;
                    end else begin
                        state_d    = FILL;
                        mem_addr_d = {cpu_addr[15:4], 4'h0};
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            WRITEBACK: begin
                if (mem_resp) begin
                    dirty_we   = 1'b1;
                    dirty_in   = 1'b0;
                    state_d    = FILL;
                    mem_addr_d = {cpu_addr[15:4], 4'h0};
                end
            end
            FILL: begin
                if (mem_resp) begin
                    data_we  = 1'b1;
                    data_sel = '1;
                    data_in  = mem_rdata;
                    tag_we   = 1'b1;
                    valid_we = 1'b1;
                    dirty_we = 1'b1;
                    dirty_in = 1'b0;
                    // Back to IDLE: the held request now hits and completes.
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Output strobes follow the next state so they are registered.
        cpu_resp_d  = (state_d == RESP);
        mem_read_d  = (state_d == FILL);
        mem_write_d = (state_d == WRITEBACK);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cpu_resp_q  <= 1'b0;
            cpu_rdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cpu_resp_q  <= cpu_resp_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign cpu_resp  = cpu_resp_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_l1_cache.sv
// Bench for l1_cache (default 8 lines): table of accesses with hand-computed
// expected memory traffic, line data and latency, plus hand-written sequences
// for reset during a fill, stray mem_resp, and back-to-back hits.
module tb_l1_cache;
    import l1_cache_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_wr_en;
    logic [15:0] cpu_wr_sel;
    logic [127:0] cpu_wdata;
    logic        cpu_resp;
    logic [127:0] cpu_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [127:0] mem_wdata;
    logic        mem_resp;
    logic [127:0] mem_rdata;
    l1_state_t   dbg_state;

    int n_cmp;
    int n_bad;

    l1_cache dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_wr_en  (cpu_wr_en),
        .cpu_wr_sel (cpu_wr_sel),
        .cpu_wdata  (cpu_wdata),
        .cpu_resp   (cpu_resp),
        .cpu_rdata  (cpu_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_resp   (mem_resp),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]  addr;
        logic         wr;
        logic [15:0]  sel;
        logic [127:0] wdata;
        logic [127:0] fill;
        logic         exp_wb;
        logic [15:0]  wb_addr;
        logic [127:0] wb_data;
        logic         exp_fill;
        logic [15:0]  fill_addr;
        logic [127:0] exp_rdata;
        int           exp_lat;
    } vec_t;

    vec_t vecs[8];

    localparam logic [127:0] L0  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] L1  = 128'h00112233_44556677_8899BEEF_CCDDEEFF;
    localparam logic [127:0] L2  = 128'hA5A5A5A5_5A5A5A5A_F0F0F0F0_0F0F0F0F;
    localparam logic [127:0] L3  = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] L4  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] L4M = 128'h770E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] L5  = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request and act as the next level: each mem request is held
    // for two sampled cycles, then answered with a one-cycle mem_resp.
    task automatic run_access(input vec_t v, input string name);
        int  wb_n;
        int  fill_n;
        bit  done;
        cpu_req    = 1'b1;
        cpu_addr   = v.addr;
        cpu_wr_en  = v.wr;
        cpu_wr_sel = v.sel;
        cpu_wdata  = v.wdata;
        wb_n   = 0;
        fill_n = 0;
        done   = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(posedge clk);
            #1;
            mem_resp = 1'b0;
            if (mem_read && mem_write) begin
                check({name, " rd_wr_exclusive"}, 1, 0);
            end
            if (mem_write) begin
                wb_n++;
                check({name, " wb_addr"}, mem_addr, v.wb_addr);
                check({name, " wb_data"}, mem_wdata, v.wb_data);
                if (wb_n == 2) mem_resp = 1'b1;
            end
            if (mem_read) begin
                fill_n++;
                check({name, " fill_addr"}, mem_addr, v.fill_addr);
                if (fill_n == 2) begin
                    mem_rdata = v.fill;
                    mem_resp  = 1'b1;
                end
            end
            if (cpu_resp) begin
                check({name, " rdata"}, cpu_rdata, v.exp_rdata);
                check({name, " latency"}, k, v.exp_lat);
                done    = 1'b1;
                cpu_req = 1'b0;
            end
        end
        if (!done) begin
            check({name, " resp_timeout"}, 0, 1);
            cpu_req = 1'b0;
        end
        check({name, " wb_cycles"}, wb_n, v.exp_wb ? 2 : 0);
        check({name, " fill_cycles"}, fill_n, v.exp_fill ? 2 : 0);
        // RESP lasts one cycle only.
        @(posedge clk);
        #1;
        check({name, " resp_single"}, cpu_resp, 0);
    endtask

    initial begin
        bit seen;
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        cpu_req    = 1'b0;
        cpu_addr   = '0;
        cpu_wr_en  = 1'b0;
        cpu_wr_sel = '0;
        cpu_wdata  = '0;
        mem_resp   = 1'b0;
        mem_rdata  = '0;

        // addr, wr, sel, wdata, fill, exp_wb, wb_addr, wb_data, exp_fill, fill_addr, rdata, lat
        vecs[0] = '{16'h1234, 1'b0, 16'h0000, 128'h0, L0, 1'b0, 16'h0, 128'h0, 1'b1, 16'h1230, L0, 4};
        vecs[1] = '{16'h123A, 1'b0, 16'h0000, 128'h0, L0, 1'b0, 16'h0, 128'h0, 1'b0, 16'h0, L0, 1};
        vecs[2] = '{16'h1234, 1'b1, 16'h0030, {80'h0, 16'hBEEF, 32'h0}, L0,
                    1'b0, 16'h0, 128'h0, 1'b0, 16'h0, L1, 1};
        vecs[3] = '{16'h5234, 1'b0, 16'h0000, 128'h0, L2, 1'b1, 16'h1230, L1, 1'b1, 16'h5230, L2, 6};
        vecs[4] = '{16'h5234, 1'b1, 16'h0000, {128{1'b1}}, L2, 1'b0, 16'h0, 128'h0, 1'b0, 16'h0, L2, 1};
        vecs[5] = '{16'h1234, 1'b0, 16'h0000, 128'h0, L3, 1'b0, 16'h0, 128'h0, 1'b1, 16'h1230, L3, 4};
        vecs[6] = '{16'h0008, 1'b1, 16'h8000, {8'h77, 120'h0}, L4,
                    1'b0, 16'h0, 128'h0, 1'b1, 16'h0000, L4M, 4};
        vecs[7] = '{16'h0400, 1'b0, 16'h0000, 128'h0, L5, 1'b1, 16'h0000, L4M, 1'b1, 16'h0400, L5, 6};

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("reset cpu_resp", cpu_resp, 0);
        check("reset mem_read", mem_read, 0);
        check("reset mem_write", mem_write, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset cpu_rdata", cpu_rdata, 0);
        check("reset state", dbg_state, IDLE);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_access(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while a fill is outstanding.
        cpu_req   = 1'b1;
        cpu_addr  = 16'h7770;
        cpu_wr_en = 1'b0;
        seen      = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (mem_read) seen = 1'b1;
        end
        check("rstfill mem_read_seen", seen, 1);
        check("rstfill fill_addr", mem_addr, 16'h7770);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstfill mem_read", mem_read, 0);
        check("rstfill mem_write", mem_write, 0);
        check("rstfill cpu_resp", cpu_resp, 0);
        check("rstfill state", dbg_state, IDLE);
        rst_n   = 1'b1;
        cpu_req = 1'b0;

        // Stray mem_resp in IDLE changes nothing.
        mem_resp = 1'b1;
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
        check("stray mem_read", mem_read, 0);
        check("stray cpu_resp", cpu_resp, 0);
        check("stray state", dbg_state, IDLE);

        // Valid bits were cleared: 0x1234 must miss and refill.
        run_access(vecs[5], "post_reset_reread");

        // Back-to-back hits with cpu_req held: one response every 2 cycles.
        cpu_req   = 1'b1;
        cpu_addr  = 16'h1234;
        cpu_wr_en = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b resp cyc%0d", k), cpu_resp, (k % 2 == 1) ? 1 : 0);
            if (cpu_resp) check($sformatf("b2b rdata cyc%0d", k), cpu_rdata, L3);
            check($sformatf("b2b no_mem cyc%0d", k), {mem_read, mem_write}, 2'b00);
        end
        cpu_req = 1'b0;
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
